counter_run_scheduler: RTL

- Shares one internal WIDTH-bit up-counter among NREQ requesters.
- Each requester asks for a counting run of a programmable length.
- Round-robin arbitration selects one requester. An FSM then sequences clear, run and completion, and flags overflow when a run would carry out of the counter.
- Sits between the counter datapath and the blocks that need timed counting windows.

---
 rtl/counter_run_scheduler_if.sv | 16 +
 rtl/counter_run_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/counter_run_scheduler_if.sv
// Requester-side handshake bundle for counter_run_scheduler: run requests,
// target lengths and abort in; grant, completion and busy status out.
interface counter_run_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  modport master (output req, len, abort, input grant, done, busy);
  modport slave  (input req, len, abort, output grant, done, busy);
endinterface

// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit up-counter among NREQ requesters;
// sequences CLEAR -> RUN -> DONE per granted run and keeps a sticky overflow flag.
module counter_run_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  counter_run_scheduler_if.slave bus,
  input  logic                  clear_ovf,
  output logic [WIDTH-1:0]      count_out,
  output logic                  overflow_out
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [NREQ-1:0]    grant_q, grant_nx;
  logic [PTR_W-1:0]   ptr, ptr_nx;
  logic [PTR_W-1:0]   owner, owner_nx;
  logic [PTR_W-1:0]   sel;
  logic               sel_vld;
  logic [WIDTH-1:0]   len_lat, len_nx;
  logic [WIDTH-1:0]   count_nx;
  logic [WIDTH:0]     count_sum;
  logic               ovf_set;
  int                 idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // First requesting index at or above the pointer, wrapping at NREQ
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!sel_vld && bus.req[idx]) begin
        sel     = PTR_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_q;
    owner_nx  = owner;
    ptr_nx    = ptr;
    len_nx    = len_lat;
    count_nx  = count_out;
    ovf_set   = 1'b0;
    count_sum = {1'b0, count_out} + STEP_EXT;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          grant_nx = NREQ'(1) << sel;
          owner_nx = sel;
          len_nx   = bus.len[int'(sel)*WIDTH +: WIDTH];
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        count_nx = '0;
        state_nx = RUN;
      end
      RUN: begin
        // Release beats completion; completion beats overflow; count never wraps
        if (bus.abort || !bus.req[owner]) begin
          grant_nx = '0;
          ptr_nx   = wrap_inc(owner);
          state_nx = IDLE;
        end else if (count_out >= len_lat) begin
          state_nx = DONE;
        end else if (count_sum[WIDTH]) begin
          ovf_set  = 1'b1;
          state_nx = DONE;
        end else begin
          count_nx = count_sum[WIDTH-1:0];
        end
      end
      DONE: begin
        grant_nx = '0;
        ptr_nx   = wrap_inc(owner);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant_q      <= '0;
      owner        <= '0;
      ptr          <= '0;
      len_lat      <= '0;
      count_out    <= '0;
      overflow_out <= 1'b0;
    end else begin
      state     <= state_nx;
      grant_q   <= grant_nx;
      owner     <= owner_nx;
      ptr       <= ptr_nx;
      len_lat   <= len_nx;
      count_out <= count_nx;
      if (ovf_set)        overflow_out <= 1'b1;
      else if (clear_ovf) overflow_out <= 1'b0;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE) ? grant_q : '0;
endmodule
